mux_share_arb: RTL and testbench
================================

# mux_share_arb

Round-robin arbiter that shares the 2:1 data mux between two requesters. Each requester raises a request and keeps it high for as long as it needs the mux. The block grants one requester at a time and drives the mux select line accordingly. It also registers the selected data, with a valid flag, for the downstream stage.

## Interface
- W, 8, data width of each mux input and of out_data
- MAX_HOLD, 4, maximum consecutive grant cycles while the other side is requesting; legal range 1..255; only used with ARB_TIMEOUT_EN

- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- req1  input  1  requester 1 wants the mux
- req2  input  1  requester 2 wants the mux
- in1  input  W  requester 1 data, routed when sel=1
- in2  input  W  requester 2 data, routed when sel=0
- gnt1  output  1  requester 1 owns the mux (registered)
- gnt2  output  1  requester 2 owns the mux (registered)
- sel  output  1  mux select: 1 = in1, 0 = in2 (registered)
- out_valid  output  1  out_data holds data from the current owner
- out_data  output  W  registered mux output

## Operation
- States: IDLE, G1, G2. Outputs per state:
  - IDLE: gnt1=0, gnt2=0, sel=0.
  - G1: gnt1=1, gnt2=0, sel=1.
  - G2: gnt1=0, gnt2=1, sel=0.
- gnt1 and gnt2 are never both 1.
- Internal state: priority pointer `last` (requester served most recently) and hold counter `cnt` (8 bits).
- IDLE transitions:
  - req1 only -> G1.
  - req2 only -> G2.
  - Both requesting -> the requester that is not `last`.
  - Neither requesting -> stay in IDLE.
  - Every entry into G1 or G2 sets `last` and clears `cnt`.
- Transitions in Gx (other requester is y):
  - reqx=0: go to Gy if reqy=1, otherwise to IDLE. The handover takes no idle bubble.
  - reqx=1 with timeout enabled, reqy=1 and cnt==MAX_HOLD-1: go to Gy (forced rotation).
  - Otherwise stay in Gx; cnt increments and saturates at MAX_HOLD-1.
- Data path, evaluated at every edge:
  - In Gx with reqx=1: out_data <= inx and out_valid <= 1.
  - All other cases: out_valid <= 0 and out_data holds its value.
- Boundary cases:
  - Simultaneous requests at reset exit: requester 1 wins.
  - A request dropped in the same cycle the grant arrives: the grant lasts one cycle and out_valid stays 0.
  - With MAX_HOLD=1 and both requesters held high: grants alternate every cycle.
  - rst asserted mid-grant: all state and outputs clear immediately, without waiting for clk.

## Timing
- Reset values: gnt1=0, gnt2=0, sel=0, out_valid=0, out_data=0, state=IDLE, cnt=0, last=requester 2. The initial `last` value gives requester 1 priority on the first arbitration.
- Request to grant: 1 cycle. A req sampled at edge N produces gnt/sel valid after edge N.
- Grant to data: 1 cycle. The first out_valid appears after the edge that follows the grant.
- Request to first valid data: 2 cycles.
- Release to release of grant: 1 cycle. A req dropped before edge N clears the grant after edge N.
- Handover: the new owner's gnt and sel take effect at the same edge where the old owner's gnt clears.
- No combinational path from any input to any output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The forced-rotation rule is active.
  - Under contention, no requester holds the mux longer than MAX_HOLD consecutive cycles.
- ARB_TIMEOUT_EN undefined:
  - The counter and the rotation rule are removed.
  - The owner keeps the grant until it drops its req; only then does the other requester get served.
  - The MAX_HOLD parameter is ignored.

## Test plan
- Reset check: assert rst, then release with req1=req2=0. Required: all outputs 0 and the block stays in IDLE.
- Single requester:
  - Stimulus: req1=1 from cycle 0, in1=8'hA5.
  - Required: gnt1=1 and sel=1 after edge 1; out_valid=1 and out_data=A5 after edge 2.
  - Drop req1: gnt1 clears 1 cycle later and out_valid falls on the same edge.
- Simultaneous requests after reset: req1=req2=1 in the same cycle.
  - Required: G1 first.
  - With ARB_TIMEOUT_EN and MAX_HOLD=4: gnt1 lasts exactly 4 cycles, then gnt2 for 4, alternating.
  - Without ARB_TIMEOUT_EN: gnt1 holds indefinitely.
- Handover: in G2, drop req2 while req1=1. Required: gnt2=0 and gnt1=1 at the same edge, with sel going 0->1 and no IDLE cycle.
- Asynchronous reset mid-burst: pulse rst between clock edges during G1. Required: gnt1, sel and out_valid fall before the next clk edge. The next arbitration with both requesting grants requester 1.
- Fairness after release: after requester 1 is served and IDLE is reached, raise both requests. Required: requester 2 is granted first.

Source files
------------

// File: rtl/mux_share_arb.sv
// mux_share_arb: round-robin arbiter sharing a 2:1 data mux between two
// requesters, with a registered data output and valid flag.
// Ports: clk, rst (async, active-high), req1/req2, in1/in2 (W bits),
//        gnt1/gnt2/sel (registered grant and mux select),
//        out_valid/out_data (registered mux output).
// Optional macro ARB_TIMEOUT_EN: forces rotation after MAX_HOLD
// consecutive grant cycles while the other side is requesting.
module mux_share_arb #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req1,
  input  logic         req2,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         gnt1,
  output logic         gnt2,
  output logic         sel,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("mux_share_arb: MAX_HOLD must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    G1,
    G2
  } state_e;

  state_e         state_q, state_d;
  // 1: requester 1 was served most recently
  logic           last_q, last_d;
  logic           gnt1_q, gnt1_d;
  logic           gnt2_q, gnt2_d;
  logic           sel_q, sel_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   data_q, data_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0]     cnt_q, cnt_d;
  logic           rot1, rot2;
  assign rot1 = req2 && (cnt_q == HOLD_LAST);
  assign rot2 = req1 && (cnt_q == HOLD_LAST);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    valid_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req1 && (!req2 || !last_q)) begin
          state_d = G1;
        end else if (req2) begin
          state_d = G2;
        end
      end
      G1: begin
        if (!req1) begin
          state_d = req2 ? G2 : IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (rot1) begin
          state_d = G2;
`endif
        end
        if (req1) begin
          valid_d = 1'b1;
          data_d  = in1;
        end
      end
      G2: begin
        if (!req2) begin
          state_d = req1 ? G1 : IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (rot2) begin
          state_d = G1;
`endif
        end
        if (req2) begin
          valid_d = 1'b1;
          data_d  = in2;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == G1 && state_q != G1) begin
      last_d = 1'b1;
    end
    if (state_d == G2 && state_q != G2) begin
      last_d = 1'b0;
    end

    // outputs registered from next state so they align with the state flop
    gnt1_d = (state_d == G1);
    gnt2_d = (state_d == G2);
    sel_d  = (state_d == G1);
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (state_q != IDLE && cnt_q != HOLD_LAST) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt1      = gnt1_q;
  assign gnt2      = gnt2_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_mux_share_arb.sv
// tb_mux_share_arb: directed scoreboard bench for mux_share_arb.
// Stimulus pushes expected outputs; a monitor pops and compares them.
module tb_mux_share_arb;

  logic       clk;
  logic       rst;
  logic       req1, req2;
  logic [7:0] in1, in2;
  logic       gnt1, gnt2, sel, out_valid;
  logic [7:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];
  event        chk_now;

  mux_share_arb #(.W(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req1      (req1),
    .req2      (req2),
    .in1       (in1),
    .in2       (in2),
    .gnt1      (gnt1),
    .gnt2      (gnt2),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1, "watchdog");
  end

  // monitor: one expectation per clock edge or explicit async check
  initial begin
    logic [11:0] e, a;
    string       nm;
    forever begin
      @(posedge clk or chk_now);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {gnt1, gnt2, sel, out_valid, out_data};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got g1=%b g2=%b sel=%b v=%b d=%h, required g1=%b g2=%b sel=%b v=%b d=%h",
                   nm, a[11], a[10], a[9], a[8], a[7:0],
                   e[11], e[10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic expect_out(input string nm, input logic g1,
                            input logic g2, input logic s,
                            input logic v, input logic [7:0] d);
    exp_q.push_back({g1, g2, s, v, d});
    name_q.push_back(nm);
  endtask

  // drive inputs at negedge; expectation is for after the next posedge
  task automatic step(input string nm, input logic r1, input logic r2,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic g1, input logic g2, input logic s,
                      input logic v, input logic [7:0] d);
    @(negedge clk);
    req1 = r1;
    req2 = r2;
    in1  = a;
    in2  = b;
    expect_out(nm, g1, g2, s, v, d);
  endtask

  task automatic areset();
    @(negedge clk);
    #1;
    rst  = 1'b1;
    req1 = 1'b0;
    req2 = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0, 8'h00);
    ->chk_now;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req1 = 1'b0;
    req2 = 1'b0;
    in1  = 8'h00;
    in2  = 8'h00;
    #3;
    expect_out("reset_state", 0, 0, 0, 0, 8'h00);
    ->chk_now;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step("idle0", 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00);
    step("idle1", 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00);

    step("r1_gnt",   1, 0, 8'hA5, 8'h00, 1, 0, 1, 0, 8'h00);
    step("r1_data",  1, 0, 8'hA5, 8'h00, 1, 0, 1, 1, 8'hA5);
    step("r1_data2", 1, 0, 8'h3C, 8'h00, 1, 0, 1, 1, 8'h3C);
    step("r1_rel",   0, 0, 8'h3C, 8'h00, 0, 0, 0, 0, 8'h3C);
    step("idle2",    0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h3C);

    step("fair_g2",  1, 1, 8'h11, 8'h22, 0, 1, 0, 0, 8'h3C);
    step("g2_data",  1, 1, 8'h11, 8'h22, 0, 1, 0, 1, 8'h22);
    step("handover", 1, 0, 8'h11, 8'h22, 1, 0, 1, 0, 8'h22);
    step("g1_data",  1, 0, 8'h33, 8'h22, 1, 0, 1, 1, 8'h33);

    areset();

    step("both_g1",  1, 1, 8'h44, 8'h55, 1, 0, 1, 0, 8'h00);
`ifdef ARB_TIMEOUT_EN
    repeat (3)
      step("hold_g1", 1, 1, 8'h44, 8'h55, 1, 0, 1, 1, 8'h44);
    step("rot_g2",   1, 1, 8'h44, 8'h55, 0, 1, 0, 1, 8'h44);
    repeat (3)
      step("hold_g2", 1, 1, 8'h44, 8'h55, 0, 1, 0, 1, 8'h55);
    step("rot_g1",   1, 1, 8'h44, 8'h55, 1, 0, 1, 1, 8'h55);
    step("rel_both", 0, 0, 8'h44, 8'h55, 0, 0, 0, 0, 8'h55);
    step("short_g2", 0, 1, 8'h00, 8'h66, 0, 1, 0, 0, 8'h55);
    step("short_rel", 0, 0, 8'h00, 8'h66, 0, 0, 0, 0, 8'h55);
`else
    repeat (6)
      step("hold_g1", 1, 1, 8'h44, 8'h55, 1, 0, 1, 1, 8'h44);
    step("rel_both", 0, 0, 8'h44, 8'h55, 0, 0, 0, 0, 8'h44);
    step("short_g2", 0, 1, 8'h00, 8'h66, 0, 1, 0, 0, 8'h44);
    step("short_rel", 0, 0, 8'h00, 8'h66, 0, 0, 0, 0, 8'h44);
`endif

    @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
